// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM, byte register
// with one-cycle done / frame-error strobes.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BRK   = 3'd4
  } state_t;

  state_t        state;
  logic          ff1, ff2;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  // rx is asynchronous; only the second flop's output is ever looked at.
  always_ff @(posedge clk) begin
    if (rst) begin
      ff1 <= 1'b1;
      ff2 <= 1'b1;
    end else begin
      ff1 <= rx;
      ff2 <= ff1;
    end
  end

  assign rx_s = ff2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      dout      <= '0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        START: begin
          // Re-check the line at the middle of the start bit to reject glitches.
          if (cnt == HALF) begin
            cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt   <= '0;
            shift <= {rx_s, shift[7:1]};
            if (bit_idx == 3'd7) state <= STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          // Leaving at mid-stop-bit lets a back-to-back start edge be caught.
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_s) begin
              dout    <= shift;
              rx_done <= 1'b1;
              state   <= IDLE;
              busy    <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BRK: begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized scoreboard bench for uart_rx: frames are described at the bit level,
// expected strobes (kind, byte, cycle) are queued and matched by a monitor.
module tb_uart_rx;

  localparam int C = 16;
  localparam int H = (C - 1) / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] dout;
  logic       rx_done;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .dout      (dout),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       q[$];
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  logic [7:0] model_dout = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && (rx_done || frame_err)) begin
      if (rx_done && frame_err) begin
        chk(1'b0, "both_strobes", 1, 0);
      end else if (q.size() == 0) begin
        chk(1'b0, "unexpected_strobe", int'(frame_err), -1);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk(frame_err == e.err, "strobe_kind", int'(frame_err), int'(e.err));
        chk(dout == e.data, "dout", int'(dout), int'(e.data));
        chk(cyc == e.cyc, "strobe_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  // Caller is at a negedge; on return the line has been idle-high or
  // released, and the call returns at a negedge.
  task automatic send(input logic [7:0] b, input bit stop_ok, input int hold_low);
    exp_t e;
    rx = 1'b0;
    e.cyc = cyc + 4 + H + 9 * C;
    e.err = !stop_ok;
    if (stop_ok) model_dout = b;
    e.data = model_dout;
    q.push_back(e);
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (C) @(negedge clk);
    end
    rx = stop_ok;
    repeat (C) @(negedge clk);
    if (!stop_ok) begin
      repeat (hold_low) @(negedge clk);
      chk(busy == 1'b1, "break_busy", int'(busy), 1);
      rx = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    chk(dout == 8'h00, "reset_dout", int'(dout), 0);
    chk(rx_done == 1'b0, "reset_rx_done", int'(rx_done), 0);
    chk(frame_err == 1'b0, "reset_frame_err", int'(frame_err), 0);
    chk(busy == 1'b0, "reset_busy", int'(busy), 0);
    rst = 1'b0;
    idle(4);

    // Nominal frame: strobe lands 155 cycles after the falling edge.
    send(8'h8A, 1'b1, 0);
    idle(5);

    // Back-to-back, no idle gap: strobes exactly 10*C apart.
    send(8'h00, 1'b1, 0);
    send(8'hFF, 1'b1, 0);
    idle(5);

    // Start glitch shorter than half a bit.
    begin
      rx = 1'b0;
      for (int k = 1; k <= 14; k++) begin
        @(negedge clk);
        if (k == 5) rx = 1'b1;
        if (k == 3)  chk(busy == 1'b1, "glitch_busy_rise", int'(busy), 1);
        if (k == 10) chk(busy == 1'b1, "glitch_busy_hold", int'(busy), 1);
        if (k == 11) chk(busy == 1'b0, "glitch_busy_fall", int'(busy), 0);
      end
      chk(dout == model_dout, "glitch_dout", int'(dout), int'(model_dout));
    end
    idle(3);

    // Frame error with a 40-cycle break, then a clean frame.
    send(8'h55, 1'b0, 40);
    idle(4);
    chk(busy == 1'b0, "break_release_idle", int'(busy), 0);
    send(8'h3C, 1'b1, 0);
    idle(4);

    // Reset in the middle of bit 4 of 0xA5; the frame is abandoned.
    begin
      logic [7:0] b;
      b = 8'hA5;
      rx = 1'b0;
      repeat (C) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        rx = b[i];
        repeat (C) @(negedge clk);
      end
      rx = b[4];
      repeat (C / 2) @(negedge clk);
      chk(busy == 1'b1, "pre_reset_busy", int'(busy), 1);
      rst = 1'b1;
      rx  = 1'b1;
      @(negedge clk);
      chk(dout == 8'h00, "midreset_dout", int'(dout), 0);
      chk(busy == 1'b0, "midreset_busy", int'(busy), 0);
      chk(rx_done == 1'b0, "midreset_rx_done", int'(rx_done), 0);
      chk(frame_err == 1'b0, "midreset_frame_err", int'(frame_err), 0);
      rst = 1'b0;
      model_dout = 8'h00;
      idle(3);
    end
    send(8'h5A, 1'b1, 0);
    idle(2);

    // Random traffic: random bytes, gaps (including none), occasional bad stop.
    for (int f = 0; f < 30; f++) begin
      logic [7:0] b;
      bit ok;
      b  = 8'($urandom_range(0, 255));
      ok = ($urandom_range(0, 5) != 0);
      send(b, ok, ok ? 0 : int'($urandom_range(2, 40)));
      idle(ok ? int'($urandom_range(0, 12)) : int'($urandom_range(3, 12)));
    end

    idle(3 * C);
    chk(q.size() == 0, "missing_strobes", q.size(), 0);
    chk(dout == model_dout, "final_dout", int'(dout), int'(model_dout));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
